hop_pulse_checker: RTL and testbench
====================================

# hop_pulse_checker

Self-checking monitor that sits directly downstream of the four-hop flop chain and consumes its `ff5` output. It taps the same `start` stimulus that feeds the chain, models the chain's fixed latency with an internal delay line, and flags any cycle where `ff5` disagrees with the delayed `start`. It also measures the latency of each isolated pulse and counts pulses that arrive, so reset-domain crossings in the chain can be characterised on silicon.

## Interface
- `LATENCY`, default 5: expected `start`→`ff5` delay in `clock0` cycles; legal range 1..63.
- `CNT_W`, default 16: width of the pulse and error counters.
- `TIMEOUT`, default 63: maximum cycles to wait for `ff5` before declaring a timeout; must be greater than `LATENCY` and at most 63.

Ports:
- `clock0` in 1: sole clock; all logic is on the rising edge.
- `rst1` in 1: reset, synchronous, active-high.
- `start` in 1: tap of the chain's `start` input.
- `ff5` in 1: chain output under test.
- `chain_rst` in 1: OR of the chain's `rst2`/`rst3`/`rst4`, already synchronised to `clock0` outside this block.
- `clear` in 1: synchronous clear of the statistics.
- `pulse_count` out `CNT_W`: number of rising edges seen on `ff5`; saturates at all-ones.
- `err_count` out `CNT_W`: number of mismatch cycles; saturates at all-ones.
- `error` out 1: sticky, set by the first mismatch.
- `latency` out 6: latency of the last completed measurement.
- `latency_valid` out 1: one-cycle pulse when `latency` updates.
- `timeout` out 1: sticky, set when no `ff5` edge arrives within `TIMEOUT` cycles.
- `busy` out 1: high while the FSM is in MEAS.

## Operation
- Priority of control inputs, highest first: `rst1`, then `chain_rst`, then `clear`.
- **`rst1`:** every output is 0, the delay line is 0, the edge registers `start_q` and `ff5_q` are 0, and the FSM is in IDLE.
- **Delay line:** a `LATENCY`-bit shift register loaded from `start` every cycle. `exp` is its oldest bit, i.e. `start` delayed by `LATENCY` cycles.
- **Compare:** in a cycle where `ff5 != exp` and `chain_rst == 0`, increment `err_count` (saturating) and set `error`.
- **Pulse count:** when `ff5 & !ff5_q`, increment `pulse_count` (saturating).
- **FSM states:** IDLE, MEAS, HOLD.
  - IDLE → MEAS on `start & !start_q`. The cycle counter is loaded with 1.
  - MEAS: the counter increments each cycle.
    - On `ff5 & !ff5_q`: set `latency` to the counter value, pulse `latency_valid`, and go to HOLD.
    - If the counter reaches `TIMEOUT`: set `timeout` and go to HOLD. `latency` is not updated.
    - Rising edges of `start` while in MEAS are ignored and do not restart the measurement.
  - HOLD → IDLE once `start == 0` and `ff5 == 0`. This prevents a long pulse from retriggering the measurement.
- **`chain_rst` high:**
  - The delay line is flushed to 0.
  - Comparison is suppressed, both in that cycle and for the next `LATENCY` cycles, using a down-counter that blanks the compare.
  - The FSM aborts to IDLE with no `latency_valid` and no `timeout`.
  - Counters are held.
- **`clear`:** zeroes `pulse_count`, `err_count`, `error`, `timeout` and `latency`, and returns the FSM to IDLE. The delay line and blanking counter are unaffected.
- **Simultaneous `clear` and an increment event:** the clear wins and the counter ends at 0.

## Timing
- Every output is registered. Counters and flags reflect an event on the clock edge after the cycle in which it is sampled.
- For a healthy chain, a single-cycle `start` pulse sampled in cycle t gives an `ff5` rising edge in cycle t+5, and `latency` = 5.
- `latency_valid` is high for exactly the one cycle after the `ff5` edge is sampled.
- Blanking after `chain_rst` falls covers cycles f through f+`LATENCY`-1, where f is the first cycle with `chain_rst` low.
- Counter saturation is at 2^`CNT_W`−1 with no wrap-around.

## Structure
- Package `hop_chk_pkg` holds:
  - the FSM state enum (IDLE, MEAS, HOLD);
  - the default constants `LATENCY_DEF` = 5 and `TIMEOUT_DEF` = 63;
  - the latency width (6).
- One sub-module, `hop_delay_line`, is a parameterised `LATENCY`-bit shift register with a synchronous flush input.
- The FSM, compare logic, blanking counter and statistics counters live in the top level.

## Test plan
- **Healthy chain:** 1-cycle `start` pulse at cycle 10, `ff5` rises at cycle 15 → `latency` = 5, `latency_valid` pulses once, `pulse_count` = 1, `err_count` = 0, `error` = 0.
- **Missing pulse:** `start` pulse with `ff5` held at 0 → `err_count` = 1 and `error` = 1 at cycle t+5; `timeout` = 1 after 63 cycles of MEAS; `latency` unchanged.
- **Chain reset mid-flight:** `chain_rst` high for 2 cycles starting at t+2 after a `start` pulse at t, with `ff5` staying at 0 → `err_count` = 0, FSM back in IDLE, no `latency_valid`, no `timeout`.
- **Saturation:** `CNT_W` = 4, drive `ff5 != exp` for 20 cycles → `err_count` stops at 15.
- **Clear versus event:** assert `clear` in the same cycle as an `ff5` rising edge → `pulse_count` = 0 in the next cycle; `rst1` asserted while in MEAS → every output is 0 on the next edge.

Source files
------------

// File: rtl/hop_chk_pkg.sv
// Shared types and constants for the hop_pulse_checker monitor.
package hop_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int LATENCY_DEF = 5;
  localparam int TIMEOUT_DEF = 63;
  localparam int LAT_W       = 6;

endpackage

// File: rtl/hop_delay_line.sv
// LATENCY-bit shift register that reproduces the chain's fixed start-to-ff5 delay.
module hop_delay_line #(
  parameter int LATENCY = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [LATENCY-1:0] taps;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < LATENCY; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[LATENCY-1];

endmodule

// File: rtl/hop_pulse_checker.sv
// Monitor for the four-hop flop chain: compares ff5 against delayed start,
// counts pulses and mismatches, and measures the latency of isolated pulses.
module hop_pulse_checker
  import hop_chk_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             start,
  input  logic             ff5,
  input  logic             chain_rst,
  input  logic             clear,
  output logic [CNT_W-1:0] pulse_count,
  output logic [CNT_W-1:0] err_count,
  output logic             error,
  output logic [LAT_W-1:0] latency,
  output logic             latency_valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [LAT_W-1:0] TIMEOUT_V = LAT_W'(TIMEOUT);
  localparam logic [LAT_W-1:0] BLANK_V   = LAT_W'(LATENCY);

  state_t           state;
  logic [LAT_W-1:0] cyc_cnt;
  logic [LAT_W-1:0] blank_cnt;
  logic             start_q;
  logic             ff5_q;
  logic             exp_bit;
  logic             start_rise;
  logic             ff5_rise;
  logic             mismatch;

  hop_delay_line #(
    .LATENCY(LATENCY)
  ) u_delay (
    .clk  (clock0),
    .rst  (rst1),
    .flush(chain_rst),
    .din  (start),
    .dout (exp_bit)
  );

  assign start_rise = start & ~start_q;
  assign ff5_rise   = ff5 & ~ff5_q;
  // The chain is mid-reset, or its pipeline still holds pre-reset data.
  assign mismatch   = (ff5 != exp_bit) && !chain_rst && (blank_cnt == '0);
  assign busy       = (state == MEAS);

  always_ff @(posedge clock0) begin
    if (rst1) begin
      start_q   <= 1'b0;
      ff5_q     <= 1'b0;
      blank_cnt <= '0;
    end else begin
      start_q <= start;
      ff5_q   <= ff5;
      if (chain_rst) begin
        blank_cnt <= BLANK_V;
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clock0) begin
    if (rst1) begin
      pulse_count <= '0;
      err_count   <= '0;
      error       <= 1'b0;
    end else if (chain_rst) begin
      pulse_count <= pulse_count;
      err_count   <= err_count;
    end else if (clear) begin
      pulse_count <= '0;
      err_count   <= '0;
      error       <= 1'b0;
    end else begin
      if (mismatch) begin
        error <= 1'b1;
        if (err_count != CNT_MAX) begin
          err_count <= err_count + 1'b1;
        end
      end
      if (ff5_rise && (pulse_count != CNT_MAX)) begin
        pulse_count <= pulse_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clock0) begin
    if (rst1) begin
      state         <= IDLE;
      cyc_cnt       <= '0;
      latency       <= '0;
      latency_valid <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      latency_valid <= 1'b0;
      if (chain_rst) begin
        state <= IDLE;
      end else if (clear) begin
        state   <= IDLE;
        latency <= '0;
        timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_rise) begin
              state   <= MEAS;
              cyc_cnt <= LAT_W'(1);
            end
          end
          MEAS: begin
            if (ff5_rise) begin
              latency       <= cyc_cnt;
              latency_valid <= 1'b1;
              state         <= HOLD;
            end else if (cyc_cnt >= TIMEOUT_V) begin
              timeout <= 1'b1;
              state   <= HOLD;
            end else begin
              cyc_cnt <= cyc_cnt + 1'b1;
            end
          end
          HOLD: begin
            // Wait for both lines to drop so a long pulse cannot retrigger.
            if (!start && !ff5) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hop_pulse_checker.sv
// Table-driven, scoreboarded bench for hop_pulse_checker (LATENCY=5, CNT_W=4, TIMEOUT=63).
module tb_hop_pulse_checker;

  typedef struct packed {
    logic       busy;
    logic       lv;
    logic [5:0] lat;
    logic       err;
    logic       to;
    logic [3:0] pc;
    logic [3:0] ec;
  } out_t;

  typedef struct {
    logic rst;
    logic start;
    logic ff5;
    logic crst;
    logic clr;
    out_t exp;
  } vec_t;

  logic       clock0 = 1'b0;
  logic       rst1 = 1'b1;
  logic       start = 1'b0;
  logic       ff5 = 1'b0;
  logic       chain_rst = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] pulse_count;
  logic [3:0] err_count;
  logic       error;
  logic [5:0] latency;
  logic       latency_valid;
  logic       timeout;
  logic       busy;

  out_t sb_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  hop_pulse_checker #(
    .LATENCY(5),
    .CNT_W  (4),
    .TIMEOUT(63)
  ) dut (
    .clock0       (clock0),
    .rst1         (rst1),
    .start        (start),
    .ff5          (ff5),
    .chain_rst    (chain_rst),
    .clear        (clear),
    .pulse_count  (pulse_count),
    .err_count    (err_count),
    .error        (error),
    .latency      (latency),
    .latency_valid(latency_valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clock0 = ~clock0;

  function automatic out_t mk(input int b, input int lv, input int lat, input int er,
                              input int to, input int pc, input int ec);
    out_t o;
    o.busy = b[0];
    o.lv   = lv[0];
    o.lat  = lat[5:0];
    o.err  = er[0];
    o.to   = to[0];
    o.pc   = pc[3:0];
    o.ec   = ec[3:0];
    return o;
  endfunction

  task automatic addVec(input logic r, input logic s, input logic f, input logic c,
                        input logic cl, input out_t e);
    vec_t v;
    v.rst = r; v.start = s; v.ff5 = f; v.crst = c; v.clr = cl; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string tag);
    out_t act;
    out_t e;
    act = {busy, latency_valid, latency, error, timeout, pulse_count, err_count};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, got %h", tag, act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("[TB] FAIL %s: got busy=%b lv=%b lat=%0d err=%b to=%b pc=%0d ec=%0d, expected busy=%b lv=%b lat=%0d err=%b to=%b pc=%0d ec=%0d",
                 tag, act.busy, act.lv, act.lat, act.err, act.to, act.pc, act.ec,
                 e.busy, e.lv, e.lat, e.err, e.to, e.pc, e.ec);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic f, input logic c,
                               input logic cl, input out_t e, input string tag);
    @(negedge clock0);
    rst1 = r; start = s; ff5 = f; chain_rst = c; clear = cl;
    sb_q.push_back(e);
    @(posedge clock0);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // reset
    addVec(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    addVec(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    // healthy chain: start then ff5 five cycles later
    addVec(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    addVec(0, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    addVec(0, 0, 1, 0, 0, mk(0, 1, 5, 0, 0, 1, 0));
    addVec(0, 0, 0, 0, 0, mk(0, 0, 5, 0, 0, 1, 0));
    addVec(0, 0, 0, 0, 0, mk(0, 0, 5, 0, 0, 1, 0));
    // clear coinciding with an ff5 rising edge
    addVec(0, 1, 0, 0, 0, mk(1, 0, 5, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 0, 0, mk(1, 0, 5, 0, 0, 1, 0));
    addVec(0, 0, 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0));
    addVec(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    // chain reset mid-flight
    addVec(0, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    addVec(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
    addVec(0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0));
    addVec(0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) addVec(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
    // blanking window after chain_rst falls: mismatch only counted at f+5
    addVec(0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) addVec(0, 0, 1, 0, 0, mk(0, 0, 0, 0, 0, 1, 0));
    addVec(0, 0, 1, 0, 0, mk(0, 0, 0, 1, 0, 1, 1));
    addVec(0, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 1, 1));
    // counters held while chain_rst is high
    addVec(0, 0, 1, 1, 0, mk(0, 0, 0, 1, 0, 1, 1));
    addVec(0, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 1, 1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].ff5, vecs[i].crst, vecs[i].clr,
                    vecs[i].exp, $sformatf("vec%0d", i));
    end

    // healthy pulse to load latency, then a missing pulse that times out
    applyStimulus(0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0), "clr1");
    applyStimulus(0, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0), "h_start");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0), "h_wait");
    applyStimulus(0, 0, 1, 0, 0, mk(0, 1, 5, 0, 0, 1, 0), "h_edge");
    applyStimulus(0, 0, 0, 0, 0, mk(0, 0, 5, 0, 0, 1, 0), "h_hold");
    applyStimulus(0, 1, 0, 0, 0, mk(1, 0, 5, 0, 0, 1, 0), "m_start");
    for (int k = 1; k <= 63; k++) begin
      applyStimulus(0, 0, 0, 0, 0,
                    mk((k < 63) ? 1 : 0, 0, 5, (k >= 5) ? 1 : 0, (k == 63) ? 1 : 0, 1,
                       (k >= 5) ? 1 : 0),
                    $sformatf("miss_k%0d", k));
    end
    applyStimulus(0, 0, 0, 0, 0, mk(0, 0, 5, 1, 1, 1, 1), "to_idle");

    // saturation of err_count at 15
    applyStimulus(0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0), "clr2");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1, 0, 0, mk(0, 0, 0, 1, 0, 1, (i + 1 < 15) ? i + 1 : 15),
                    $sformatf("sat%0d", i));
    end
    applyStimulus(0, 0, 0, 0, 0, mk(0, 0, 0, 1, 0, 1, 15), "sat_end");

    // rst1 while in MEAS clears everything on the next edge
    applyStimulus(0, 1, 0, 0, 0, mk(1, 0, 0, 1, 0, 1, 15), "r_start");
    applyStimulus(0, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 1, 15), "r_meas");
    applyStimulus(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0), "r_reset");
    applyStimulus(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0), "r_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
